// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider
package clk_div_pkg;
   localparam int CLK_DIV_MIN   = 2;
   localparam int CLK_DIV_W_DEF = 8;
   function automatic logic [31:0] half(input logic [31:0] d);
      return d >> 1;
   endfunction
endpackage

// File: rtl/clk_div_odd_stretch.sv
// clk_div_odd_stretch: half-cycle stretch giving 50 % duty for odd divisors (used under CLK_DIV_ODD_DUTY_EN)
module clk_div_odd_stretch (
   input  logic clk,
   input  logic rst_n,
   input  logic out_pos,
   input  logic odd,
   output logic out
);
   logic out_neg_d, out_neg_q;
   always_comb out_neg_d = out_pos;
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) out_neg_q <= 1'b0;
      else        out_neg_q <= out_neg_d;
   end
   // odd only changes at a wrap where out_pos rises, so the OR cannot glitch
   assign out = out_pos | (odd & out_neg_q);
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider with boundary-synchronous divisor apply; CLK_DIV_ODD_DUTY_EN enables odd 50 % duty
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int DIV_W     = CLK_DIV_W_DEF,
   parameter int DIV_RESET = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_pend,
   output logic [DIV_W-1:0] div_act,
   output logic             tick,
   output logic             out
);
   logic [DIV_W-1:0] cnt_d, cnt_q, act_d, act_q, pval_d, pval_q, cnt_nxt, h;
   logic             pend_d, pend_q, out_pos_d, out_pos_q, tick_d, tick_q;
   logic             running, apply;
   always_comb begin
      h         = DIV_W'(half(32'(act_q)));
      running   = en && (act_q >= DIV_W'(CLK_DIV_MIN));
      // >= rather than == so a stale count beyond the period still wraps
      cnt_nxt   = (cnt_q >= act_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
      apply     = pend_q && (!running || cnt_nxt == '0);
      cnt_d     = running ? cnt_nxt : '1;
      out_pos_d = running && (cnt_nxt < h);
      tick_d    = running && (cnt_nxt == '0);
      act_d     = apply ? pval_q : act_q;
      pval_d    = div_load ? div_in : pval_q;
      pend_d    = div_load || (pend_q && !apply);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= DIV_W'(DIV_RESET - 1);
         act_q     <= DIV_W'(DIV_RESET);
         pval_q    <= '0;
         pend_q    <= 1'b0;
         out_pos_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         act_q     <= act_d;
         pval_q    <= pval_d;
         pend_q    <= pend_d;
         out_pos_q <= out_pos_d;
         tick_q    <= tick_d;
      end
   end
   assign div_pend = pend_q;
   assign div_act  = act_q;
   assign tick     = tick_q;
`ifdef CLK_DIV_ODD_DUTY_EN
   clk_div_odd_stretch u_stretch (
      .clk     (clk),
      .rst_n   (rst_n),
      .out_pos (out_pos_q),
      .odd     (act_q[0]),
      .out     (out)
   );
`else
   assign out = out_pos_q;
`endif
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: randomized and directed checks of clk_div_prog against a phase-based reference model
module tb_clk_div_prog;
`ifdef CLK_DIV_ODD_DUTY_EN
   localparam int ODD = 1;
`else
   localparam int ODD = 0;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       div_load = 1'b0;
   logic [7:0] div_in = '0;
   logic       div_pend, tick, out;
   logic [7:0] div_act;
   int         n_cmp = 0, n_bad = 0;
   int         m_act, m_pval, m_ph;
   bit         m_pend, m_fresh, m_pos, m_neg, m_tick;

   clk_div_prog #(.DIV_W(8), .DIV_RESET(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .div_pend (div_pend),
      .div_act  (div_act),
      .tick     (tick),
      .out      (out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_act = 2; m_pval = 0; m_ph = 0;
      m_pend = 0; m_fresh = 1; m_pos = 0; m_neg = 0; m_tick = 0;
   endtask

   // phase within the current period; a fresh start always lands on phase 0
   task automatic m_edge(input bit e, input bit ld, input int d);
      bit run, bnd;
      run = e && m_act >= 2;
      m_neg = m_pos;
      if (run) begin
         m_ph    = (m_fresh || m_ph == m_act - 1) ? 0 : m_ph + 1;
         m_fresh = 0;
         m_pos   = m_ph < m_act / 2;
         m_tick  = m_ph == 0;
         bnd     = m_ph == 0;
      end else begin
         m_fresh = 1; m_pos = 0; m_tick = 0; bnd = 1;
      end
      if (m_pend && bnd) begin m_act = m_pval; m_pend = 0; end
      if (ld) begin m_pval = d; m_pend = 1; end
   endtask

   task automatic compare_all();
      chk("out", out, 32'(m_pos | (ODD[0] & m_act[0] & m_neg)));
      chk("tick", tick, 32'(m_tick));
      chk("div_act", div_act, m_act);
      chk("div_pend", div_pend, 32'(m_pend));
   endtask

   task automatic cyc(input bit e, input bit ld, input int d);
      @(negedge clk);
      en = e; div_load = ld; div_in = 8'(d);
      @(posedge clk);
      m_edge(e, ld, d);
      #1 compare_all();
   endtask

   task automatic measure(input int d);
      int hi, i;
      for (i = 0; i < 200 && !(tick && div_act == 8'(d)); i++) cyc(1, 0, 0);
      chk("sync", 32'(tick && div_act == 8'(d)), 1);
      hi = int'(out);
      for (int k = 1; k < d; k++) begin
         cyc(1, 0, 0);
         hi += int'(out);
      end
      cyc(1, 0, 0);
      chk("period_tick", tick, 1);
      chk("high_cycles", hi, (d + ODD) / 2);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      m_reset();
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      int seen7;
      m_reset();
      en = 1'b1;
      #1 rst_n = 1'b0;
      #2 compare_all();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1, 0, 0);
      cyc(1, 1, 6);
      chk("pend_after_load", div_pend, 1);
      measure(6);
      cyc(1, 1, 5);
      measure(5);
      cyc(1, 0, 0);
      cyc(1, 1, 7);
      cyc(1, 1, 4);
      seen7 = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0, 0);
         if (div_act == 8'd7) seen7++;
      end
      chk("never_7", seen7, 0);
      measure(4);
      cyc(1, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0);
      chk("stopped_out", out, 0);
      cyc(1, 0, 0);
      chk("restart_tick", tick, 1);
      chk("restart_out", out, 1);
      measure(4);
      cyc(1, 1, 1);
      for (int i = 0; i < 8; i++) cyc(1, 0, 0);
      chk("d1_act", div_act, 1);
      chk("d1_out", out, 0);
      cyc(1, 1, 3);
      cyc(1, 0, 0);
      chk("d3_applied", div_act, 3);
      cyc(1, 0, 0);
      chk("d3_tick", tick, 1);
      cyc(1, 1, 9);
      cyc(1, 0, 0);
      async_reset();
      chk("rst_pend", div_pend, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) async_reset();
         cyc($urandom_range(0, 15) != 0, $urandom_range(0, 14) == 0, int'($urandom_range(0, 12)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
